// File: rtl/adder_tree_pipe.sv
// adder_tree_pipe: registered binary adder tree, valid/ready on both sides.
// Optional frame accumulate; define ADDER_TREE_SAT_EN to saturate the accumulator.
module adder_tree_pipe #(
  parameter int BITS     = 8,
  parameter int NUM      = 4,
  parameter int SIGNED   = 0,
  parameter int ACCUM    = 0,
  parameter int ACC_BITS = 8,
  localparam int LEVELS   = (NUM > 1) ? $clog2(NUM) : 0,
  localparam int SUM_BITS = BITS + LEVELS,
  localparam int OUT_BITS = SUM_BITS + ((ACCUM != 0) ? ACC_BITS : 0)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic [NUM*BITS-1:0] data_in,
  output logic [OUT_BITS-1:0] o,
  output logic                valid_out,
  input  logic                ready_out,
  output logic                overflow
);

  function automatic int cnt_at(input int k);
    int c;
    c = NUM;
    for (int i = 0; i < k; i++) c = (c + 1) / 2;
    return c;
  endfunction

  logic [LEVELS:0]   vld;
  logic [LEVELS+1:0] rdy;
  logic              down_rdy;
  logic [SUM_BITS-1:0] tree_sum;

  // ready ripples back from the consumer; bubbles collapse
  always_comb begin
    rdy[LEVELS+1] = down_rdy;
    for (int k = LEVELS; k >= 0; k--)
      rdy[k] = !vld[k] || rdy[k+1];
  end

  assign in_ready = rdy[0];

  // one valid bit per stage, advancing when that stage is ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      if (rdy[0]) vld[0] <= valid;
      for (int k = 1; k <= LEVELS; k++)
        if (rdy[k]) vld[k] <= vld[k-1];
    end
  end

  for (genvar k = 0; k <= LEVELS; k++) begin : g_lv
    localparam int CNT = cnt_at(k);
    localparam int W   = BITS + k;
    logic [CNT*W-1:0] d;
    logic [CNT*W-1:0] nxt;

    if (k == 0) begin : g_in
      assign nxt = data_in;
    end else begin : g_add
      localparam int PC = cnt_at(k - 1);
      localparam int PW = W - 1;
      for (genvar j = 0; j < CNT; j++) begin : g_el
        logic [PW-1:0] a;
        assign a = g_lv[k-1].d[2*j*PW +: PW];
        if (2 * j + 1 < PC) begin : g_pair
          logic [PW-1:0] b;
          assign b = g_lv[k-1].d[(2*j+1)*PW +: PW];
          assign nxt[j*W +: W] =
            {(SIGNED != 0) && a[PW-1], a} +
            {(SIGNED != 0) && b[PW-1], b};
        end else begin : g_pass
          assign nxt[j*W +: W] = {(SIGNED != 0) && a[PW-1], a};
        end
      end
    end

    // tree level register, held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) d <= '0;
      else if (rdy[k]) d <= nxt;
    end
  end

  assign tree_sum = g_lv[LEVELS].d;

  if (ACCUM == 0) begin : g_direct
    logic unused_last;
    assign unused_last = in_last;
    assign down_rdy    = ready_out;
    assign o           = tree_sum;
    assign valid_out   = vld[LEVELS];
    assign overflow    = 1'b0;
  end else begin : g_acc
    logic [LEVELS:0]     lst;
    logic [OUT_BITS-1:0] acc;
    logic [OUT_BITS-1:0] ext;
    logic [OUT_BITS-1:0] total;
    logic [OUT_BITS-1:0] res;
    logic sx;
    logic carry;
    logic ovf;
    logic take;

    // last marker rides alongside the valid bits
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lst <= '0;
      end else begin
        if (rdy[0]) lst[0] <= in_last;
        for (int k = 1; k <= LEVELS; k++)
          if (rdy[k]) lst[k] <= lst[k-1];
      end
    end

    // extend tree sum, add, flag wrap; only a last beat needs o free
    always_comb begin
      sx = (SIGNED != 0) && tree_sum[SUM_BITS-1];
      ext = {{ACC_BITS{sx}}, tree_sum};
      {carry, total} = {1'b0, acc} + {1'b0, ext};
      if (SIGNED != 0)
        ovf = (acc[OUT_BITS-1] == ext[OUT_BITS-1]) &&
              (total[OUT_BITS-1] != acc[OUT_BITS-1]);
      else
        ovf = carry;
      res = total;
`ifdef ADDER_TREE_SAT_EN
      if (ovf) begin
        if (SIGNED == 0)
          res = '1;
        else if (acc[OUT_BITS-1])
          res = {1'b1, {(OUT_BITS-1){1'b0}}};
        else
          res = {1'b0, {(OUT_BITS-1){1'b1}}};
      end
`endif
      down_rdy = !lst[LEVELS] || !valid_out || ready_out;
      take = vld[LEVELS] && down_rdy;
    end

    // accumulator and output register; last beat emits and clears
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc       <= '0;
        o         <= '0;
        valid_out <= 1'b0;
        overflow  <= 1'b0;
      end else begin
        if (valid_out && ready_out) valid_out <= 1'b0;
        if (take) begin
          overflow <= overflow || ovf;
          if (lst[LEVELS]) begin
            o         <= res;
            valid_out <= 1'b1;
            acc       <= '0;
          end else begin
            acc <= res;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// tb_adder_tree_pipe: scoreboard bench, three configurations of the tree.
// Reference sums come from plain integer arithmetic over the beat elements.
module tb_adder_tree_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit lat_chk = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A: NUM=4 unsigned, one output per beat
  logic a_valid, a_rdy, a_last, a_vo, a_ro, a_ovf;
  logic [31:0] a_data;
  logic [9:0]  a_o;
  bit a_rnd = 0;
  int a_q[$];
  int a_t[$];

  // S: NUM=3 signed, one output per beat
  logic s_valid, s_rdy, s_last, s_vo, s_ro, s_ovf;
  logic [23:0] s_data;
  logic [9:0]  s_o;
  bit s_rnd = 0;
  int s_q[$];

  // B: NUM=2 unsigned, accumulate with 1 headroom bit
  logic b_valid, b_rdy, b_last, b_vo, b_ro, b_ovf;
  logic [15:0] b_data;
  logic [9:0]  b_o;
  bit b_rnd = 0;
  int b_q[$];
  bit b_fq[$];
  int b_acc = 0;
  bit b_sticky = 0;

  adder_tree_pipe #(.BITS(8), .NUM(4), .SIGNED(0), .ACCUM(0)) u_a (
    .clk(clk), .rst_n(rst_n), .valid(a_valid), .in_ready(a_rdy),
    .in_last(a_last), .data_in(a_data), .o(a_o), .valid_out(a_vo),
    .ready_out(a_ro), .overflow(a_ovf));

  adder_tree_pipe #(.BITS(8), .NUM(3), .SIGNED(1), .ACCUM(0)) u_s (
    .clk(clk), .rst_n(rst_n), .valid(s_valid), .in_ready(s_rdy),
    .in_last(s_last), .data_in(s_data), .o(s_o), .valid_out(s_vo),
    .ready_out(s_ro), .overflow(s_ovf));

  adder_tree_pipe #(.BITS(8), .NUM(2), .SIGNED(0), .ACCUM(1),
                    .ACC_BITS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .valid(b_valid), .in_ready(b_rdy),
    .in_last(b_last), .data_in(b_data), .o(b_o), .valid_out(b_vo),
    .ready_out(b_ro), .overflow(b_ovf));

  task automatic check(input string name, input longint act,
                       input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expire(input string name);
    total++;
    bad++;
    $display("FAIL %s: handshake bound expired at %0t", name, $time);
  endtask

  task automatic spurious(input string name, input longint v);
    total++;
    bad++;
    $display("FAIL %s: output %0d with nothing pending", name, v);
  endtask

  function automatic int sum_u(input logic [31:0] d, input int n);
    int s;
    s = 0;
    for (int i = 0; i < n; i++) s += int'(d[i*8 +: 8]);
    return s;
  endfunction

  function automatic int sum_s(input logic [31:0] d, input int n);
    int s;
    byte e;
    s = 0;
    for (int i = 0; i < n; i++) begin
      e = d[i*8 +: 8];
      s += e;
    end
    return s;
  endfunction

  task automatic send_a(input logic [31:0] d);
    int n;
    n = 0;
    a_valid = 1'b1;
    a_data = d;
    #1;
    while (!a_rdy && n < 500) begin @(negedge clk); #1; n++; end
    if (a_rdy) begin
      a_q.push_back(sum_u(d, 4));
      a_t.push_back(cyc);
    end else expire("a_send");
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic send_s(input logic [31:0] d);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data = d[23:0];
    #1;
    while (!s_rdy && n < 500) begin @(negedge clk); #1; n++; end
    if (s_rdy) s_q.push_back(sum_s(d, 3));
    else expire("s_send");
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_b(input logic [15:0] d, input bit last);
    int n;
    n = 0;
    b_valid = 1'b1;
    b_data = d;
    b_last = last;
    #1;
    while (!b_rdy && n < 500) begin @(negedge clk); #1; n++; end
    if (b_rdy) begin
      b_acc += int'(d[7:0]) + int'(d[15:8]);
      if (b_acc > 1023) begin
        b_sticky = 1;
`ifdef ADDER_TREE_SAT_EN
        b_acc = 1023;
`else
        b_acc -= 1024;
`endif
      end
      if (last) begin
        b_q.push_back(b_acc);
        b_fq.push_back(b_sticky);
        b_acc = 0;
      end
    end else expire("b_send");
    @(negedge clk);
    b_valid = 1'b0;
    b_last = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (a_q.size() + s_q.size() + b_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, a_q.size() + s_q.size() + b_q.size(), 0);
  endtask

  task automatic rand_a(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send_a($urandom);
    end
  endtask

  task automatic rand_s(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send_s($urandom);
    end
  endtask

  task automatic rand_b(input int frames);
    int nb;
    for (int f = 0; f < frames; f++) begin
      nb = $urandom_range(1, 4);
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        send_b(16'($urandom), i == nb - 1);
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (a_rnd) a_ro = ($urandom_range(0, 3) != 0);
    if (s_rnd) s_ro = ($urandom_range(0, 2) != 0);
    if (b_rnd) b_ro = ($urandom_range(0, 3) != 0);
  end

  initial begin : mon_a
    logic hold;
    logic [9:0] prev;
    int e;
    int t;
    hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) hold = 1'b0;
      else begin
        if (hold) begin
          check("a_hold_valid", a_vo, 1);
          check("a_hold_o", a_o, prev);
        end
        if (a_vo && a_ro) begin
          if (a_q.size() == 0) spurious("a_out", a_o);
          else begin
            e = a_q.pop_front();
            t = a_t.pop_front();
            check("a_sum", a_o, e);
            if (lat_chk) check("a_latency", cyc - t, 3);
          end
        end
        hold = a_vo && !a_ro;
        prev = a_o;
      end
    end
  end

  initial begin : mon_s
    logic hold;
    logic [9:0] prev;
    int e;
    hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) hold = 1'b0;
      else begin
        if (hold) begin
          check("s_hold_valid", s_vo, 1);
          check("s_hold_o", s_o, prev);
        end
        if (s_vo && s_ro) begin
          if (s_q.size() == 0) spurious("s_out", s_o);
          else begin
            e = s_q.pop_front();
            check("s_sum", $signed(s_o), e);
          end
        end
        hold = s_vo && !s_ro;
        prev = s_o;
      end
    end
  end

  initial begin : mon_b
    logic hold;
    logic [9:0] prev;
    int e;
    bit f;
    hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) hold = 1'b0;
      else begin
        if (hold) begin
          check("b_hold_valid", b_vo, 1);
          check("b_hold_o", b_o, prev);
        end
        if (b_vo && !hold && b_fq.size() != 0)
          check("b_overflow", b_ovf, b_fq[0]);
        if (b_vo && b_ro) begin
          if (b_q.size() == 0) spurious("b_out", b_o);
          else begin
            e = b_q.pop_front();
            f = b_fq.pop_front();
            check("b_sum", b_o, e);
          end
        end
        hold = b_vo && !b_ro;
        prev = b_o;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    a_valid = 0; a_last = 0; a_data = '0; a_ro = 1;
    s_valid = 0; s_last = 0; s_data = '0; s_ro = 1;
    b_valid = 0; b_last = 0; b_data = '0; b_ro = 1;

    repeat (3) @(negedge clk);
    #1;
    check("rst_a_o", a_o, 0);
    check("rst_a_valid", a_vo, 0);
    check("rst_s_valid", s_vo, 0);
    check("rst_b_o", b_o, 0);
    check("rst_b_valid", b_vo, 0);
    check("rst_b_ovf", b_ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_a_in_ready", a_rdy, 1);
    check("rst_s_in_ready", s_rdy, 1);
    check("rst_b_in_ready", b_rdy, 1);
    @(negedge clk);

    lat_chk = 1;
    send_a(32'h04030201);
    send_a(32'hFFFFFFFF);
    send_s(32'h0005FEFF);
    drain("drain_directed");
    lat_chk = 0;

    a_ro = 1'b0;
    a_valid = 1'b1;
    a_data = 32'h01010101;
    n = 0;
    repeat (6) begin
      #1;
      if (a_rdy) begin
        a_q.push_back(sum_u(a_data, 4));
        a_t.push_back(cyc);
        n++;
      end
      @(negedge clk);
    end
    #1;
    check("a_fill_count", n, 3);
    check("a_in_ready_full", a_rdy, 0);
    check("a_stall_o", a_o, 4);
    check("a_stall_valid", a_vo, 1);
    a_valid = 1'b0;
    @(negedge clk);
    a_ro = 1'b1;
    repeat (8 - n) send_a(32'h01010101);
    drain("drain_stall");

    send_b(16'h140A, 0);
    send_b(16'h281E, 0);
    send_b(16'h3C32, 1);
    send_b(16'h0101, 1);
    drain("drain_frames");
    check("b_ovf_clear", b_ovf, 0);
    send_b(16'hFFFF, 0);
    send_b(16'hFFFF, 0);
    send_b(16'hFFFF, 1);
    drain("drain_wrap");

    a_rnd = 1;
    s_rnd = 1;
    b_rnd = 1;
    fork
      rand_a(60);
      rand_s(60);
      rand_b(20);
    join
    drain("drain_random");
    a_rnd = 0; a_ro = 1;
    s_rnd = 0; s_ro = 1;
    b_rnd = 0; b_ro = 1;
    check("a_ovf_never", a_ovf, 0);
    check("s_ovf_never", s_ovf, 0);

    @(negedge clk);
    send_b(16'h1111, 0);
    send_b(16'h2222, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_b_o", b_o, 0);
    check("midrst_b_valid", b_vo, 0);
    check("midrst_b_ovf", b_ovf, 0);
    b_acc = 0;
    b_sticky = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", b_rdy, 1);
    @(negedge clk);
    send_b(16'h0403, 1);
    drain("drain_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
